// File: rtl/bp_pkg.sv
// Shared types for the branch-predictor control block: PC-select codes,
// controller FSM states and the table write-buffer entry.
package bp_pkg;

    typedef enum logic [1:0] {
        PC_SEQ  = 2'b00,
        PC_PRED = 2'b01,
        PC_FALL = 2'b10,
        PC_TGT  = 2'b11
    } pc_sel_e;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_RECOVER = 1'b1
    } bp_state_e;

    // Widest table index a buffered write can carry; narrower tables zero-extend.
    localparam int BP_IDX_MAX_W = 16;

    typedef struct packed {
        logic [BP_IDX_MAX_W-1:0] idx;
        logic                    wrt;
        logic                    wrp;
        logic                    pred;
    } wb_entry_t;

endpackage

// File: rtl/bp_wbuf.sv
// Prediction-table write buffer: synchronous FIFO of pending table updates
// with full/empty flags and wrap-around pointers (DEPTH a power of two).
module bp_wbuf
    import bp_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      i_push,
    input  wb_entry_t i_data,
    input  logic      i_pop,
    output wb_entry_t o_head,
    output logic      o_full,
    output logic      o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wb_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop & ~o_empty;
    // A push at full is only taken alongside a pop, which frees the head slot.
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_head    = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/bp_ctrl.sv
// Branch-predictor control: D/E tracking, branch resolution, redirect FSM and
// table-port sharing through a write buffer. Optional stats: BP_CTRL_STATS_EN.
module bp_ctrl
    import bp_pkg::*;
#(
    parameter int IDX_W    = 4,
    parameter int WB_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fe_valid,
    input  logic [IDX_W-1:0] fe_idx,
    input  logic             lk_hit,
    input  logic             lk_pred,
    input  logic             ex_is_br,
    input  logic             ex_taken,
    output logic             tbl_re,
    output logic             tbl_we,
    output logic [IDX_W-1:0] tbl_addr,
    output logic             tbl_wrt,
    output logic             tbl_wrp,
    output logic             tbl_wpred,
    output logic [1:0]       pc_sel,
    output logic             flush,
    output logic             stall_fe
`ifdef BP_CTRL_STATS_EN
    ,
    output logic [15:0]      br_cnt,
    output logic [15:0]      mispred_cnt
`endif
);

    bp_state_e        r_state;
    bp_state_e        w_state_nxt;
    pc_sel_e          r_pc_sel;
    pc_sel_e          w_pc_sel_nxt;
    logic             r_d_valid, r_d_hd, r_d_pd;
    logic [IDX_W-1:0] r_d_idx;
    logic             r_e_valid, r_e_hd, r_e_pd;
    logic [IDX_W-1:0] r_e_idx;
    logic             w_resolve;
    logic             w_redirect;
    logic             w_enq;
    wb_entry_t        w_enq_data;
    wb_entry_t        w_head;
    logic             w_wb_full;
    logic             w_wb_empty;

    assign stall_fe  = (r_state == ST_RECOVER) | w_wb_full;
    // rst_n keeps the read port quiet while reset is held.
    assign tbl_re    = rst_n & fe_valid & ~stall_fe;
    assign tbl_we    = ~tbl_re & ~w_wb_empty;
    assign tbl_addr  = tbl_re ? fe_idx : (tbl_we ? IDX_W'(w_head.idx) : '0);
    assign tbl_wrt   = tbl_we & w_head.wrt;
    assign tbl_wrp   = tbl_we & w_head.wrp;
    assign tbl_wpred = tbl_we & w_head.pred;
    assign pc_sel    = r_pc_sel;
    assign flush     = (r_state == ST_RECOVER);

    always_comb begin
        w_resolve    = r_e_valid & ex_is_br;
        w_enq        = 1'b0;
        w_redirect   = 1'b0;
        w_enq_data   = '0;
        w_pc_sel_nxt = PC_SEQ;
        if (w_resolve) begin
            w_enq_data.idx  = BP_IDX_MAX_W'(r_e_idx);
            w_enq_data.wrp  = 1'b1;
            w_enq_data.pred = ex_taken;
            if (!r_e_hd) begin
                // Allocate on a miss; only a taken miss needs a redirect.
                w_enq          = 1'b1;
                w_enq_data.wrt = 1'b1;
                w_redirect     = ex_taken;
            end else if (ex_taken != r_e_pd) begin
                w_enq      = 1'b1;
                w_redirect = 1'b1;
            end
        end
        if (w_redirect) begin
            w_pc_sel_nxt = ex_taken ? PC_TGT : PC_FALL;
        end else if (tbl_re && lk_hit && lk_pred) begin
            w_pc_sel_nxt = PC_PRED;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:     if (w_redirect) w_state_nxt = ST_RECOVER;
            ST_RECOVER: w_state_nxt = ST_RUN;
            default:    w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_RUN;
            r_pc_sel <= PC_SEQ;
        end else begin
            r_state  <= w_state_nxt;
            r_pc_sel <= w_pc_sel_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d_valid <= 1'b0;
            r_d_idx   <= '0;
            r_d_hd    <= 1'b0;
            r_d_pd    <= 1'b0;
            r_e_valid <= 1'b0;
            r_e_idx   <= '0;
            r_e_hd    <= 1'b0;
            r_e_pd    <= 1'b0;
        end else if (w_redirect) begin
            r_d_valid <= 1'b0;
            r_e_valid <= 1'b0;
        end else if (!stall_fe) begin
            r_d_valid <= fe_valid;
            r_d_idx   <= fe_idx;
            r_d_hd    <= lk_hit;
            r_d_pd    <= lk_pred;
            r_e_valid <= r_d_valid;
            r_e_idx   <= r_d_idx;
            r_e_hd    <= r_d_hd;
            r_e_pd    <= r_d_pd;
        end else begin
            // E has already resolved this cycle; D waits for fetch to resume.
            r_e_valid <= 1'b0;
        end
    end

    bp_wbuf #(
        .DEPTH (WB_DEPTH)
    ) u_wbuf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_enq),
        .i_data  (w_enq_data),
        .i_pop   (tbl_we),
        .o_head  (w_head),
        .o_full  (w_wb_full),
        .o_empty (w_wb_empty)
    );

`ifdef BP_CTRL_STATS_EN
    logic [15:0] r_br_cnt;
    logic [15:0] r_mispred_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_br_cnt      <= '0;
            r_mispred_cnt <= '0;
        end else begin
            if (w_resolve && (r_br_cnt != 16'hFFFF)) begin
                r_br_cnt <= r_br_cnt + 16'd1;
            end
            if (w_redirect && (r_mispred_cnt != 16'hFFFF)) begin
                r_mispred_cnt <= r_mispred_cnt + 16'd1;
            end
        end
    end

    assign br_cnt      = r_br_cnt;
    assign mispred_cnt = r_mispred_cnt;
`endif

endmodule
